fifo_stream_reader: RTL and testbench

//  Read-side master for the fifo block: drives rd_en and samples data_out/empty.
//  Re-presents popped words on a valid/ready stream towards downstream logic.
//  An internal skid buffer absorbs the FIFO's one-cycle read latency, so no word is lost.

---
 rtl/fifo_stream_reader_pkg.sv | 6 +
 rtl/fifo_stream_reader_if.sv | 16 +
 rtl/fifo_stream_reader_skid_buf.sv | 42 ++++
 rtl/fifo_stream_reader.sv | 50 +++++
 tb/tb_fifo_stream_reader.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/fifo_stream_reader_pkg.sv
// fifo_stream_reader_pkg: shared word type and default sizes for the FIFO stream reader
package fifo_stream_reader_pkg;
  localparam int DEF_FIFO_WIDTH = 8;
  localparam int DEF_SKID_DEPTH = 3;
  typedef logic [DEF_FIFO_WIDTH-1:0] fifo_word_t;
endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: FIFO read port plus valid/ready stream bundle
// master = reader (drives rd_en, m_valid, m_data); slave = fifo read side + stream consumer
interface fifo_stream_reader_if
  import fifo_stream_reader_pkg::*;
#(
  parameter int W = DEF_FIFO_WIDTH
);
  logic         rd_en;
  logic         empty;
  logic [W-1:0] data_out;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  modport master (output rd_en, m_valid, m_data, input empty, data_out, m_ready);
  modport slave  (input rd_en, m_valid, m_data, output empty, data_out, m_ready);
endinterface

// File: rtl/fifo_stream_reader_skid_buf.sv
// fifo_stream_reader_skid_buf: circular skid buffer catching words popped from the FIFO
// ports: clk, rstN (async, active low), push/push_data in, pop in, pop_data/occ/empty out
module fifo_stream_reader_skid_buf
  import fifo_stream_reader_pkg::*;
#(
  parameter int W = DEF_FIFO_WIDTH,
  parameter int DEPTH = DEF_SKID_DEPTH,
  localparam int OW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic [OW-1:0] occ,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign pop_data = mem[rd_ptr];
  assign empty = (occ == '0);
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mem <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      occ <= occ + OW'(push) - OW'(pop);
    end
  end
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops the FIFO and re-presents words on a valid/ready stream
// ports: clk, rstN (async, active low), enable, bus (master: fifo read port + stream),
//        rd_count (handshakes, wrapping), busy (word in flight or buffered)
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int SKID_DEPTH = DEF_SKID_DEPTH,
  parameter int CNT_WIDTH = 32,
  localparam int OW = $clog2(SKID_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 enable,
  fifo_stream_reader_if.master bus,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic                 busy
);
  logic          inflight;
  logic          sk_empty;
  logic          hs;
  logic [OW-1:0] occ;
  assign hs = bus.m_valid && bus.m_ready;
  // in-flight word counts against capacity so a full buffer can never be overrun
  assign bus.rd_en = enable && !bus.empty && ((OW+1)'(occ) + (OW+1)'(inflight) < (OW+1)'(SKID_DEPTH));
  assign bus.m_valid = !sk_empty;
  assign busy = inflight || !sk_empty;
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      inflight <= 1'b0;
      rd_count <= '0;
    end else begin
      inflight <= bus.rd_en;
      rd_count <= rd_count + CNT_WIDTH'(hs);
    end
  end
  fifo_stream_reader_skid_buf #(
    .W(FIFO_WIDTH),
    .DEPTH(SKID_DEPTH)
  ) u_skid (
    .clk(clk),
    .rstN(rstN),
    .push(inflight),
    .push_data(bus.data_out),
    .pop(hs),
    .pop_data(bus.m_data),
    .occ(occ),
    .empty(sk_empty)
  );
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed bench with a behavioural FIFO and an ordering scoreboard
module tb_fifo_stream_reader;
  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       enable = 1'b0;
  logic [4:0] rd_count;
  logic       busy;
  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  int pops = 0;
  logic [7:0] last_data = '0;
  logic [7:0] fq[$];
  logic [7:0] wq[$];
  logic [7:0] exp_q[$];
  fifo_stream_reader_if #(.W(8)) bus ();
  fifo_stream_reader #(.FIFO_WIDTH(8), .SKID_DEPTH(3), .CNT_WIDTH(5)) dut (
    .clk(clk),
    .rstN(rstN),
    .enable(enable),
    .bus(bus),
    .rd_count(rd_count),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic fifo_write(input logic [7:0] w);
    wq.push_back(w);
    exp_q.push_back(w);
  endtask
  // behavioural fifo: writes land at the next edge, reads return data one edge after rd_en
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      fq.delete();
      wq.delete();
      bus.empty <= 1'b1;
      bus.data_out <= '0;
    end else begin
      if (bus.rd_en && fq.size() != 0) begin
        bus.data_out <= fq.pop_front();
        pops++;
      end
      while (wq.size() != 0) fq.push_back(wq.pop_front());
      bus.empty <= (fq.size() == 0);
    end
  end
  always @(negedge clk) begin
    if (rstN) begin
      if (bus.rd_en) chk("rd_en_while_empty", 32'(bus.empty), 32'd0);
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", 32'(bus.m_data), 32'hFFFF_FFFF);
        else chk("m_data_order", 32'(bus.m_data), 32'(exp_q.pop_front()));
        last_data <= bus.m_data;
        hs_cnt++;
      end
    end
  end
  initial begin
    int re, mv, nre, first, last, h0, p0;
    bit got;
    bus.m_ready = 1'b0;
    #50;
    chk("rst_rd_en", 32'(bus.rd_en), 0);
    chk("rst_m_valid", 32'(bus.m_valid), 0);
    chk("rst_m_data", 32'(bus.m_data), 0);
    chk("rst_rd_count", 32'(rd_count), 0);
    chk("rst_busy", 32'(busy), 0);
    #50 rstN = 1'b1;
    enable = 1'b1;
    tick(3);
    chk("idle_rd_en", 32'(bus.rd_en), 0);
    chk("idle_m_valid", 32'(bus.m_valid), 0);
    chk("idle_rd_count", 32'(rd_count), 0);
    bus.m_ready = 1'b1;
    fifo_write(8'hA5);
    re = -1; mv = -1; nre = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.rd_en) begin
        nre++;
        if (re < 0) re = c;
      end
      if (bus.m_valid && mv < 0) mv = c;
    end
    chk("single_seen", 32'(re >= 0 && mv >= 0), 1);
    chk("single_latency", 32'(mv - re), 2);
    chk("single_rd_en_cycles", 32'(nre), 1);
    chk("single_hs", 32'(hs_cnt), 1);
    chk("single_rd_count", 32'(rd_count), 1);
    tick(1);
    h0 = hs_cnt;
    for (int i = 0; i < 16; i++) fifo_write(8'(i));
    first = -1; last = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.m_valid && bus.m_ready) begin
        if (first < 0) first = c;
        last = c;
      end
    end
    chk("stream_consecutive", 32'(last - first), 15);
    chk("stream_hs", 32'(hs_cnt - h0), 16);
    chk("stream_rd_count", 32'(rd_count), 17);
    tick(1);
    bus.m_ready = 1'b0;
    p0 = pops;
    h0 = hs_cnt;
    for (int i = 0; i < 16; i++) fifo_write(8'h40 + 8'(i));
    tick(10);
    chk("bp_m_data_mid", 32'(bus.m_data), 32'h40);
    tick(10);
    chk("bp_pops", 32'(pops - p0), 3);
    chk("bp_rd_en", 32'(bus.rd_en), 0);
    chk("bp_m_valid", 32'(bus.m_valid), 1);
    chk("bp_m_data", 32'(bus.m_data), 32'h40);
    bus.m_ready = 1'b1;
    tick(40);
    chk("bp_release_hs", 32'(hs_cnt - h0), 16);
    chk("bp_rd_count_wrap", 32'(rd_count), 1);
    chk("bp_busy", 32'(busy), 0);
    p0 = pops;
    h0 = hs_cnt;
    for (int i = 0; i < 4; i++) fifo_write(8'h50 + 8'(i));
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (bus.rd_en) got = 1;
    end
    chk("en_rd_en_seen", 32'(got), 1);
    @(posedge clk);
    #1 enable = 1'b0;
    tick(10);
    chk("en_off_pops", 32'(pops - p0), 1);
    chk("en_off_hs", 32'(hs_cnt - h0), 1);
    chk("en_off_rd_en", 32'(bus.rd_en), 0);
    chk("en_off_busy", 32'(busy), 0);
    enable = 1'b1;
    tick(20);
    chk("en_on_pops", 32'(pops - p0), 4);
    chk("en_on_hs", 32'(hs_cnt - h0), 4);
    chk("en_rd_count", 32'(rd_count), 5);
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) fifo_write(8'h60 + 8'(i));
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (bus.m_valid) got = 1;
    end
    chk("mid_m_valid_seen", 32'(got), 1);
    @(posedge clk);
    #1;
    chk("mid_full_rd_en", 32'(bus.rd_en), 0);
    chk("mid_busy", 32'(busy), 1);
    rstN = 1'b0;
    #1;
    chk("mid_rst_m_valid", 32'(bus.m_valid), 0);
    chk("mid_rst_rd_count", 32'(rd_count), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_m_data", 32'(bus.m_data), 0);
    exp_q.delete();
    tick(2);
    rstN = 1'b1;
    tick(1);
    bus.m_ready = 1'b1;
    h0 = hs_cnt;
    fifo_write(8'h3C);
    tick(10);
    chk("post_rst_hs", 32'(hs_cnt - h0), 1);
    chk("post_rst_data", 32'(last_data), 32'h3C);
    chk("post_rst_rd_count", 32'(rd_count), 1);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
